// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debounce/synchronizer stage.
// State encodings and defaults used by the RTL, benches and neighbouring stages.
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } db_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 10;
    localparam int DEF_CNT_W       = 4;

    function automatic logic is_checking(db_state_t st);
        return (st == CHK_HI) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Plain flop chain bringing an asynchronous level into the clk domain.
// All stages clear to 0 on synchronous reset.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic d_out
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    assign chain_d = {chain_q[SYNC_STAGES-2:0], d_in};

    // shift the raw level through the synchronizer stages
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign d_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizer plus stability-counter FSM with rise/fall strobes.
// A new level must be seen STABLE_CNT consecutive cycles before d_clean follows.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic d_raw,
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_clean_q, d_clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_in (d_raw),
        .d_out(s)
    );

    // next state: qualify a level change, any return to the old level restarts
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_clean_d = d_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = IDLE_HI;
                    d_clean_d = 1'b1;
                    rise_d    = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = IDLE_LO;
                    d_clean_d = 1'b0;
                    fall_d    = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
        busy_d = is_checking(state_d);
    end

    // state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_LO;
            cnt_q     <= '0;
            d_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
        end
    end

    assign d_clean = d_clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = busy_q;

endmodule
